// File: rtl/arbitro_pkg.sv
// Shared constants for the VC-to-destination demultiplexer: word width,
// FSM state encodings and destination select encodings.
package arbitro_pkg;

  localparam int DATA_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2
  } state_t;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

endpackage

// File: rtl/contador_push.sv
// Free-running wrap counter of accepted pushes; advances by one per enable.
module contador_push #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (en)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/demux_destino.sv
// Routes the valid VC word (VC0 has priority) to destination FIFO D0 or D1
// by one data bit, tracking push counts, sticky errors and activity state.
module demux_destino #(
  parameter int DATA_W   = arbitro_pkg::DATA_W,
  parameter int DEST_BIT = 4,
  parameter int CNT_W    = 5,
  parameter int IDLE_TO  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pop_delay_VC0,
  input  logic              pop_delay_VC1,
  input  logic [DATA_W-1:0] data_VC0,
  input  logic [DATA_W-1:0] data_VC1,
  input  logic              full_fifo_D0,
  input  logic              full_fifo_D1,
  input  logic              err_clr,
  output logic              push_D0,
  output logic              push_D1,
  output logic [DATA_W-1:0] data_D0,
  output logic [DATA_W-1:0] data_D1,
  output logic [CNT_W-1:0]  cnt_D0,
  output logic [CNT_W-1:0]  cnt_D1,
  output logic              err_both,
  output logic              err_ovf,
  output logic [1:0]        state
);

  import arbitro_pkg::*;

  localparam int IDLE_W = $clog2(IDLE_TO + 1);

  logic              valid;
  logic              dest;
  logic              full_sel;
  logic              accept;
  logic              push0_nxt;
  logic              push1_nxt;
  logic              set_both;
  logic              set_ovf;
  logic              err_evt;
  logic [DATA_W-1:0] sel;

  state_t            state_q;
  state_t            state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_nxt;

  // A word headed for a full FIFO is dropped rather than stalled.
  always_comb begin
    valid     = pop_delay_VC0 | pop_delay_VC1;
    sel       = pop_delay_VC0 ? data_VC0 : data_VC1;
    dest      = sel[DEST_BIT];
    full_sel  = (dest == DEST_D1) ? full_fifo_D1 : full_fifo_D0;
    accept    = valid & ~full_sel;
    push0_nxt = accept & (dest == DEST_D0);
    push1_nxt = accept & (dest == DEST_D1);
    set_both  = pop_delay_VC0 & pop_delay_VC1;
    set_ovf   = valid & full_sel;
    err_evt   = set_both | set_ovf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_D0 <= 1'b0;
      push_D1 <= 1'b0;
      data_D0 <= '0;
      data_D1 <= '0;
    end else begin
      push_D0 <= push0_nxt;
      push_D1 <= push1_nxt;
      if (push0_nxt)
        data_D0 <= sel;
      if (push1_nxt)
        data_D1 <= sel;
    end
  end

  // A new error event takes precedence over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_both <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      if (set_both)
        err_both <= 1'b1;
      else if (err_clr)
        err_both <= 1'b0;
      if (set_ovf)
        err_ovf <= 1'b1;
      else if (err_clr)
        err_ovf <= 1'b0;
    end
  end

  contador_push #(.CNT_W(CNT_W)) u_cnt_d0 (
    .clk   (clk),
    .reset (reset),
    .en    (push0_nxt),
    .count (cnt_D0)
  );

  contador_push #(.CNT_W(CNT_W)) u_cnt_d1 (
    .clk   (clk),
    .reset (reset),
    .en    (push1_nxt),
    .count (cnt_D1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idle_cnt <= '0;
    end else begin
      state_q  <= state_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  // Idle count only advances in ACTIVE; it is cleared by any valid word.
  always_comb begin
    state_nxt = state_q;
    idle_nxt  = '0;
    case (state_q)
      IDLE: begin
        if (err_evt)
          state_nxt = ERROR;
        else if (valid)
          state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (err_evt) begin
          state_nxt = ERROR;
        end else if (!valid) begin
          if (idle_cnt == IDLE_W'(IDLE_TO - 1))
            state_nxt = IDLE;
          else
            idle_nxt = idle_cnt + IDLE_W'(1);
        end
      end
      ERROR: begin
        if (!err_evt && err_clr)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_demux_destino.sv
// Scoreboard bench for demux_destino: directed vectors queue expected pushes,
// a negedge monitor pops and compares every push the DUT presents.
module tb_demux_destino;

  localparam int DATA_W = 6;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              pop_delay_VC0, pop_delay_VC1;
  logic [DATA_W-1:0] data_VC0, data_VC1;
  logic              full_fifo_D0, full_fifo_D1;
  logic              err_clr;
  logic              push_D0, push_D1;
  logic [DATA_W-1:0] data_D0, data_D1;
  logic [CNT_W-1:0]  cnt_D0, cnt_D1;
  logic              err_both, err_ovf;
  logic [1:0]        state;

  typedef struct {
    logic              dest;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
  } push_t;

  push_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  demux_destino dut (
    .clk           (clk),
    .reset         (reset),
    .pop_delay_VC0 (pop_delay_VC0),
    .pop_delay_VC1 (pop_delay_VC1),
    .data_VC0      (data_VC0),
    .data_VC1      (data_VC1),
    .full_fifo_D0  (full_fifo_D0),
    .full_fifo_D1  (full_fifo_D1),
    .err_clr       (err_clr),
    .push_D0       (push_D0),
    .push_D1       (push_D1),
    .data_D0       (data_D0),
    .data_D1       (data_D1),
    .cnt_D0        (cnt_D0),
    .cnt_D1        (cnt_D1),
    .err_both      (err_both),
    .err_ovf       (err_ovf),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic expectPush(input logic dest, input logic [DATA_W-1:0] data,
                            input logic [CNT_W-1:0] cnt);
    push_t e;
    e.dest = dest;
    e.data = data;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic p0, input logic p1,
                               input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                               input logic f0, input logic f1, input logic clr);
    pop_delay_VC0 = p0;
    pop_delay_VC1 = p1;
    data_VC0      = d0;
    data_VC1      = d1;
    full_fifo_D0  = f0;
    full_fifo_D1  = f1;
    err_clr       = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input logic clr);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, clr);
  endtask

  // Monitor: every presented push must match the oldest expected push.
  initial begin
    push_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        checkOutput("push_exclusive", int'(push_D0 & push_D1), 0);
        if (push_D0 || push_D1) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_push", 1, 0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("push_dest", int'(push_D1), int'(e.dest));
            checkOutput("push_data", int'(push_D1 ? data_D1 : data_D0), int'(e.data));
            checkOutput("push_cnt", int'(push_D1 ? cnt_D1 : cnt_D0), int'(e.cnt));
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    pop_delay_VC0 = 1'b0; pop_delay_VC1 = 1'b0;
    data_VC0 = '0; data_VC1 = '0;
    full_fifo_D0 = 1'b0; full_fifo_D1 = 1'b0;
    err_clr = 1'b0;
    #12;
    checkOutput("rst_push_D0", int'(push_D0), 0);
    checkOutput("rst_cnt_D1", int'(cnt_D1), 0);
    checkOutput("rst_err_both", int'(err_both), 0);
    checkOutput("rst_state", int'(state), 0);
    @(negedge clk);
    reset = 1'b0;

    // Routing: bit4 set sends VC0 word to D1
    expectPush(1'b1, 6'h13, 5'd1);
    applyStimulus(1'b1, 1'b0, 6'h13, 6'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("route_push_D0", int'(push_D0), 0);
    checkOutput("route_cnt_D1", int'(cnt_D1), 1);
    checkOutput("route_cnt_D0", int'(cnt_D0), 0);
    checkOutput("route_state", int'(state), 1);

    // Idle timeout: ACTIVE for three more idle cycles, IDLE on the fourth
    for (int i = 1; i <= 4; i++) begin
      idleCycle(1'b0);
      checkOutput($sformatf("timeout_state_%0d", i), int'(state), (i == 4) ? 0 : 1);
    end
    checkOutput("hold_data_D1", int'(data_D1), 'h13);

    // A valid on idle cycle 3 restarts the timeout
    expectPush(1'b0, 6'h05, 5'd1);
    applyStimulus(1'b0, 1'b1, 6'h00, 6'h05, 1'b0, 1'b0, 1'b0);
    checkOutput("restart_state_a", int'(state), 1);
    idleCycle(1'b0);
    idleCycle(1'b0);
    expectPush(1'b0, 6'h06, 5'd2);
    applyStimulus(1'b1, 1'b0, 6'h06, 6'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("restart_state_b", int'(state), 1);
    for (int i = 1; i <= 4; i++) begin
      idleCycle(1'b0);
      checkOutput($sformatf("restart_idle_%0d", i), int'(state), (i == 4) ? 0 : 1);
    end

    // Collision: VC0 wins, VC1 dropped, err_both, ERROR
    expectPush(1'b0, 6'h02, 5'd3);
    applyStimulus(1'b1, 1'b1, 6'h02, 6'h15, 1'b0, 1'b0, 1'b0);
    checkOutput("coll_push_D1", int'(push_D1), 0);
    checkOutput("coll_err_both", int'(err_both), 1);
    checkOutput("coll_state", int'(state), 2);
    checkOutput("coll_cnt_D1", int'(cnt_D1), 1);
    idleCycle(1'b1);
    checkOutput("clr_err_both", int'(err_both), 0);
    checkOutput("clr_state", int'(state), 0);

    // Overflow: D0 full, VC1 word dropped
    applyStimulus(1'b0, 1'b1, 6'h00, 6'h01, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf_push_D0", int'(push_D0), 0);
    checkOutput("ovf_err_ovf", int'(err_ovf), 1);
    checkOutput("ovf_cnt_D0", int'(cnt_D0), 3);
    checkOutput("ovf_data_D0", int'(data_D0), 'h02);
    checkOutput("ovf_state", int'(state), 2);

    // Routing continues in ERROR
    expectPush(1'b1, 6'h1F, 5'd2);
    applyStimulus(1'b0, 1'b1, 6'h00, 6'h1F, 1'b0, 1'b0, 1'b0);
    checkOutput("err_route_state", int'(state), 2);

    // Clear coinciding with a new overflow: error wins
    applyStimulus(1'b1, 1'b0, 6'h10, 6'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_vs_ovf_flag", int'(err_ovf), 1);
    checkOutput("clr_vs_ovf_state", int'(state), 2);
    checkOutput("clr_vs_ovf_cnt_D1", int'(cnt_D1), 2);
    idleCycle(1'b1);
    checkOutput("clr2_err_ovf", int'(err_ovf), 0);
    checkOutput("clr2_state", int'(state), 0);
    idleCycle(1'b1);
    checkOutput("clr_idle_state", int'(state), 0);

    // Reset between a valid and its edge cancels the push
    pop_delay_VC0 = 1'b1;
    data_VC0      = 6'h13;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_cnt_D0", int'(cnt_D0), 0);
    checkOutput("async_cnt_D1", int'(cnt_D1), 0);
    checkOutput("async_data_D0", int'(data_D0), 0);
    checkOutput("async_data_D1", int'(data_D1), 0);
    @(posedge clk);
    #1;
    checkOutput("rst_mid_push_D1", int'(push_D1), 0);
    checkOutput("rst_mid_state", int'(state), 0);
    pop_delay_VC0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Wrap: 32 pushes return cnt_D0 to 0, the 33rd gives 1
    for (int i = 0; i < 33; i++) begin
      expectPush(1'b0, DATA_W'(i % 16), CNT_W'((i + 1) % 32));
      applyStimulus(1'b1, 1'b0, DATA_W'(i % 16), 6'h00, 1'b0, 1'b0, 1'b0);
      if (i == 31) checkOutput("wrap_cnt_0", int'(cnt_D0), 0);
      if (i == 32) checkOutput("wrap_cnt_1", int'(cnt_D0), 1);
    end

    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
